// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with fully registered handshake outputs.
// in_ready comes straight from a flop, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state, state_n;
    logic             main_valid, skid_valid, in_ready_q;
    logic [WIDTH-1:0] main_data, main_data_n;
    logic [WIDTH-1:0] skid_data, skid_data_n;
    logic [1:0]       occ_q;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid & out_ready;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n     = state;
        main_data_n = main_data;
        skid_data_n = skid_data;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n     = ONE;
                    main_data_n = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_n = in_data;
                end else if (in_fire) begin
                    state_n     = TWO;
                    skid_data_n = in_data;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_n     = ONE;
                    main_data_n = skid_data;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state      <= state_n;
            main_valid <= (state_n != EMPTY);
            skid_valid <= (state_n == TWO);
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
            in_ready_q <= (state_n != TWO);
            occ_q      <= (state_n == TWO) ? 2'd2 : (state_n == ONE) ? 2'd1 : 2'd0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus randomized scoreboard run for pipe_skid_reg.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic        eir;
        logic [1:0]  eocc;
        logic        chkd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic        ir_seen;
        logic        in_fire, out_fire;

        // rst flush iv data ordy | ev edata eir eocc chkd
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1});
        // streaming 1..4
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 32'h1,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 32'h2,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 32'h3,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 32'h4,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0});
        // backpressure A, B, C held
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 32'hA,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  1'b0, 2'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  1'b0, 2'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 32'hB,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 32'hC,  1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0});
        // flush while TWO with both handshakes requested
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h12, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1});
        // rst and flush together with two beats held
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h21, 1'b0, 1'b1, 32'h21, 1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h21, 1'b0, 2'd2, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h23, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1});

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].eir));
            check($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
            if (vecs[i].ev || vecs[i].chkd)
                check($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].ed));
        end

        // Randomized run against a FIFO model; stage starts EMPTY after the last vector.
        rst   = 1'b0;
        flush = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            ir_seen   = in_ready;
            out_ready = ~out_ready;
            #1;
            check("rand in_ready indep of out_ready", 64'(in_ready), 64'(ir_seen));
            out_ready = ~out_ready;
            #1;
            check("rand occupancy", 64'(occupancy), 64'(q.size()));
            check("rand in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("rand out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0)
                check("rand out_data", 64'(out_data), 64'(q[0]));
            in_fire  = in_valid && (q.size() < 2);
            out_fire = out_ready && (q.size() > 0);
            @(posedge clk);
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(in_data);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001: Parameter WIDTH, default 32, data payload width in bits (WIDTH >= 1).
REQ-002: clk  input  1  clock; all state updates on posedge clk.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: flush  input  1  synchronous pipeline clear, active-high, discards all held beats.
REQ-005: in_valid  input  1  upstream beat present.
REQ-006: in_ready  output  1  stage can accept a beat this cycle.
REQ-007: in_data  input  WIDTH  upstream payload.
REQ-008: out_valid  output  1  downstream beat present.
REQ-009: out_ready  input  1  downstream accepts this cycle.
REQ-010: out_data  output  WIDTH  downstream payload.
REQ-011: occupancy  output  2  number of held beats, 0..2.

Function
REQ-012: Storage SHALL be a main register (drives out_data) plus one skid register, each with its own valid bit.
REQ-013: States SHALL be EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid); no other state reachable.
REQ-014: in_ready SHALL be driven directly from a register and equal 1 exactly when the skid register is empty (EMPTY or ONE); no combinational path from out_ready to in_ready.
REQ-015: out_valid SHALL equal the main valid bit; out_data SHALL equal the main data register; both registered outputs.
REQ-016: Input handshake fires when in_valid & in_ready; output handshake fires when out_valid & out_ready.
REQ-017: EMPTY: input fire -> ONE, main <= in_data; otherwise stay EMPTY.
REQ-018: ONE, input fire and output fire -> stay ONE, main <= in_data.
REQ-019: ONE, input fire, no output fire -> TWO, skid <= in_data, main unchanged.
REQ-020: ONE, output fire, no input fire -> EMPTY.
REQ-021: ONE, neither fires -> hold.
REQ-022: TWO: input handshake impossible (in_ready=0); output fire -> ONE, main <= skid; otherwise hold.
REQ-023: Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data after edge N when the stage was EMPTY or emptying.
REQ-024: Ordering SHALL be strict FIFO; no beat duplicated or lost except by flush/rst.
REQ-025: Throughput SHALL be one beat per cycle while out_ready stays high.
REQ-026: flush SHALL, at the next edge, force EMPTY, clear both valid bits, and zero both data registers; any handshake in the flush cycle SHALL be discarded.
REQ-027: in_data and out_data contents while the corresponding valid is 0 SHALL be the last written value (0 after rst/flush); benches SHALL check data only when valid.
REQ-028: occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-029: In_valid asserted while in_ready=0 SHALL NOT change state; upstream holds the beat.

Reset
REQ-030: rst SHALL have priority over flush and all handshakes.
REQ-031: On rst: state EMPTY, out_valid 0, out_data 0, skid data 0, occupancy 0, in_ready 1 from the first edge after rst asserted.
REQ-032: rst asserted mid-transfer SHALL drop all held beats; no beat emitted the cycle after rst.

Verification
REQ-033: Streaming: out_ready=1, in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready constant 1, occupancy 1.
REQ-034: Backpressure: accept 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready 0, out_data 0xA; in_valid with 0xC held; raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss.
REQ-035: Flush in TWO with in_valid=1 and out_ready=1 -> next cycle out_valid 0, occupancy 0, in_ready 1, out_data 0; no beat emitted from that cycle.
REQ-036: rst and flush asserted together with beats in flight -> reset values per REQ-031.
REQ-037: Random in_valid/out_ready (10k cycles, scoreboard) -> output sequence equals accepted input sequence, occupancy never exceeds 2, in_ready never depends on same-cycle out_ready.
